// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Advances one pixel for each rising edge of the divided pixel clock (sampled
// as a level in the clk_in domain). It produces registered hsync, vsync and
// video_on, together with the current pixel coordinates, all describing the
// same position. pixel_x and pixel_y come straight from the counter registers.
module vga_sync_gen #(
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           pix_clk,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           pix_tick,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  // Raster boundaries pre-sized to the counter widths so every compare is
  // width-matched.
  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS    = X_W'(H_DISP);
  localparam logic [Y_W-1:0] V_VIS    = Y_W'(V_DISP);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_DISP + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_DISP + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_DISP + V_FP + V_SYNC - 1);

  logic           pix_clk_d;
  logic           tick;
  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic [X_W-1:0] h_nxt;
  logic [Y_W-1:0] v_nxt;
  logic           hsync_nxt;
  logic           vsync_nxt;
  logic           video_on_nxt;
  logic           frame_wrap;

  // One tick per pix_clk rising edge, however long pix_clk stays high.
  assign tick = pix_clk & ~pix_clk_d;

  // The frame wraps on the tick that leaves the last pixel of the last line.
  assign frame_wrap = tick && (h == H_LAST) && (v == V_LAST);

  // Next raster position. Without a tick it equals the current one, so the
  // registered decode below simply holds.
  always_comb begin
    // NOTE: every always_comb output is given a default before any branch so
    // that no path leaves it unassigned; a missing default infers a latch.
    h_nxt = h;
    v_nxt = v;
    if (tick) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  // Decode sync and blanking from the next position. Once registered, they
  // line up with the counters and cannot glitch.
  always_comb begin
    hsync_nxt    = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt    = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // Pixel-clock edge history, raster counters and all registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pix_clk_d   <= 1'b0;
      h           <= '0;
      v           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every
      // right-hand side reads the value from before this edge.
      pix_clk_d   <= pix_clk;
      h           <= h_nxt;
      v           <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_on_nxt;
      pix_tick    <= tick;
      frame_start <= frame_wrap;
    end
  end

  assign pixel_x = h;
  assign pixel_y = v;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the divided pixel clock (25 MHz square wave from the /4 divider) as a level signal in the clk_in domain.
- Produces VGA horizontal/vertical sync, the display-enable and the current pixel coordinates for the pixel/colour generators.
- Fully synchronous to clk_in and advances one pixel per detected rising edge of the pixel clock. Default timing is 640x480@60.

Parameters:
H_DISP, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_DISP, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, sync active level (0 = active-low)
X_W, 10, pixel_x width; must hold H_TOTAL-1
Y_W, 10, pixel_y width; must hold V_TOTAL-1

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_clk  in  1  divided pixel clock level (any duty cycle, synchronous to clk_in)
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
video_on  out  1  high while (pixel_x < H_DISP) and (pixel_y < V_DISP), registered
pixel_x  out  X_W  current column 0..H_TOTAL-1
pixel_y  out  Y_W  current line 0..V_TOTAL-1
pix_tick  out  1  one-clk_in pulse, same cycle the counters advance
frame_start  out  1  one-clk_in pulse when position becomes (0,0)

Behaviour:
- Edge detect: pix_clk_d <= pix_clk each clk_in edge. tick = pix_clk & ~pix_clk_d is combinational. Exactly one tick per pix_clk rising edge, regardless of how many cycles pix_clk stays high.
- On a clk_in edge with tick=1:
  - h <= (h == H_TOTAL-1) ? 0 : h+1.
  - On h wrap: v <= (v == V_TOTAL-1) ? 0 : v+1. Otherwise v holds.
- With tick=0, all counters and outputs hold.
- hsync, vsync and video_on are decoded from the next-state (h,v) and registered on the same edge. All outputs therefore always describe the same position, with no glitches.
- hsync = SYNC_POL when H_DISP+H_FP <= h <= H_DISP+H_FP+H_SYNC-1 (default 656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL when V_DISP+V_FP <= v <= V_DISP+V_FP+V_SYNC-1 (default 490..491); otherwise ~SYNC_POL. Vsync is line-based: it changes only at the h wrap.
- pixel_x = h and pixel_y = v, driven directly from the counter registers.
- pix_tick is a registered copy of tick: high for the one cycle after the advancing edge.
- frame_start is registered: high for one cycle after the edge where (h,v) went (H_TOTAL-1,V_TOTAL-1) -> (0,0).
- Reset (async, any time, including mid-line or mid-sync):
  - h=0, v=0, pix_clk_d=0.
  - hsync = vsync = ~SYNC_POL, video_on=1 (decode of (0,0)).
  - pix_tick=0, frame_start=0.
  - If pix_clk is high at the first edge after reset release, a tick occurs on that edge.
- Arithmetic: counter compares are exact equality. No overflow is possible given the X_W/Y_W constraint. Counters never reach H_TOTAL or V_TOTAL.
- Duty/phase of pix_clk is irrelevant; only rising edges count. A pix_clk held constant freezes the raster.

Test Plan:
- Reset, then pix_clk = clk_in/4 square wave (2 high/2 low): pix_tick every 4 clk_in cycles; pixel_x reaches 799, then 0 with pixel_y=1 after 800 ticks = 3200 clk_in.
- Hsync window, defaults: hsync low exactly for pixel_x 656..751 (96 ticks = 384 clk_in), high elsewhere; video_on drops when pixel_x goes 639->640 and rises at 799->0 (pixel_y<480).
- Full frame: vsync low only for pixel_y 490..491 (1600 ticks); frame_start single pulse every 420000 ticks = 1,680,000 clk_in; pixel_y wraps 524->0 together with pixel_x 799->0.
- pix_clk held high for 10 cycles, then low 10 cycles, repeated: exactly one tick per high phase; pixel_x advances by 1 per 20 clk_in.
- Assert reset at pixel (700,491) during active hsync/vsync: same cycle hsync=vsync=1, pixel_x=pixel_y=0, video_on=1, pix_tick=frame_start=0; counting resumes from 0 after release.
- SYNC_POL=1, H_DISP=4, H_FP=1, H_SYNC=2, H_BP=1, V_DISP=2, V_FP=1, V_SYNC=1, V_BP=1: hsync high for x=5..6, vsync high for y=3, H_TOTAL=8, V_TOTAL=5, frame_start every 40 ticks.
